alu_resp_unit: RTL
==================

# alu_resp_unit

Sequential responder for the ALU operation stream: accepts `{f, a, b}` requests over a valid/ready handshake, computes the result, and returns `{y, flags}` responses in request order through a 2-entry response FIFO with backpressure. Single-cycle ops complete on acceptance. MUL is a 32-cycle shift-add multiply run by a small FSM. It sits between an operation issuer (vector sequencer or decode stage) and whatever consumes results.

## Interface
Parameters:
- WIDTH, 32, operand/result width (only 32 is supported)
- CNTW, 16, width of the delivered-response counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_f  in  4  function code
- req_a, req_b  in  32  signed operands
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes head this cycle
- rsp_y  out  32  result at FIFO head
- rsp_flags  out  4  {n, z, c, v} at FIFO head
- rsp_err  out  1  head came from an illegal f
- op_count  out  CNTW  responses delivered; wraps

## Operation
- Function codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 a&~b
  - 0101 a|~b
  - 0110 SUB (a-b)
  - 0111 SLT signed (y = 1 or 0)
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA (shift amount = b[4:0])
  - 1011 MUL (low 32 bits of a*b)
  - 1100–1111 illegal: y=0, err=1
- Flags:
  - z = (y==0).
  - n = y[31].
  - ADD: c = carry out of bit 31; v = signed overflow.
  - SUB: computed as a+~b+1. c = carry out, so 1 means no borrow; v = signed overflow.
  - All other ops: c = v = 0.
- Handshake: a transfer occurs on a rising edge where valid&&ready.
  - req_ready = (state==IDLE) && (fifo_count<2). It is combinational from registered state only, with no dependence on req_valid.
  - rsp side is a standard valid/ready FIFO pop. Head outputs are held stable while rsp_valid && !rsp_ready.
- FSM states:
  - IDLE: a non-MUL accept pushes its result into the FIFO on the same edge. A MUL accept loads the multiplicand and multiplier, clears the accumulator, sets cnt=0, and moves to MUL.
  - MUL: each edge processes one multiplier bit (add shifted a if bit set) and increments cnt. On the edge where cnt==31, push the result and return to IDLE.
- FIFO: 2 entries, in-order. Push and pop on the same edge are legal, and count is unchanged.
  - A MUL push can never find the FIFO full, because the request was accepted with count≤1 and nothing else pushes during MUL. An assertion checks this.
- op_count increments on every rsp handshake and wraps from 2^CNTW-1 to 0.
- Reset (async, any time, including mid-MUL):
  - State goes to IDLE, the FIFO empties, and any in-progress MUL is discarded with no response.
  - Outputs: rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_err=0, op_count=0.
  - req_ready reads 1 (IDLE, empty), but no transfers occur while rst=1.

## Timing
- Single-cycle op accepted at edge E: rsp_valid=1 after E if the FIFO was empty. Latency is 1 cycle.
- MUL accepted at edge E0:
  - req_ready=0 after E0 through E32.
  - Result is pushed at E32; rsp_valid=1 after E32 if the FIFO was empty.
  - req_ready returns to 1 after E32 if count<2.
- Back-to-back single-cycle ops sustain 1 per cycle while rsp_ready=1.
- FIFO full with rsp_ready=0: req_ready=0. Popping at edge E gives req_ready=1 after E.
- Consecutive MULs issue every 33 cycles.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001 -> y=0x80000000, flags=1001 (n,v), err=0, rsp_valid one cycle after accept.
- SUB a=5, b=5 -> y=0, flags=0110 (z,c). SLT a=-1, b=1 -> y=1, flags=0000. SRA a=0x80000000, b=4 -> y=0xF8000000, flags=1000.
- MUL a=0xFFFFFFFF, b=3 -> y=0xFFFFFFFD, flags=1000. rsp_valid exactly 32 edges after accept; req_ready=0 during that interval.
- rsp_ready=0, issue ADD 1+1, ADD 2+2, ADD 3+3 -> the third stalls (req_ready=0 after 2 accepts). Raise rsp_ready -> responses arrive in order 2, 4, 6; op_count=3.
- Illegal f=1100, a=b=0x12345678 -> y=0, err=1, flags=0100.
- Assert rst 10 cycles into a MUL -> rsp_valid=0 immediately, with no MUL response after release. The next ADD 1+2 returns 3 with op_count=1.

Source files
------------

// File: rtl/alu_resp_unit.sv
// alu_resp_unit
//   Sequential ALU responder. Accepts {f, a, b} requests over valid/ready,
//   computes the result, and returns {y, flags, err} in request order
//   through a 2-entry response FIFO. Single-cycle ops push on acceptance;
//   MUL runs a 32-step shift-add sequence before pushing.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; req_f function, req_a/req_b operands
//   rsp_valid/rsp_ready   response FIFO head handshake
//   rsp_y, rsp_flags      head result and {n, z, c, v}
//   rsp_err               head came from an illegal function code
//   op_count              delivered responses, wraps
module alu_resp_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_f,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err,
   output logic [CNTW-1:0]  op_count
);

   localparam logic [3:0] F_AND  = 4'b0000;
   localparam logic [3:0] F_OR   = 4'b0001;
   localparam logic [3:0] F_ADD  = 4'b0010;
   localparam logic [3:0] F_XOR  = 4'b0011;
   localparam logic [3:0] F_ANDN = 4'b0100;
   localparam logic [3:0] F_ORN  = 4'b0101;
   localparam logic [3:0] F_SUB  = 4'b0110;
   localparam logic [3:0] F_SLT  = 4'b0111;
   localparam logic [3:0] F_SLL  = 4'b1000;
   localparam logic [3:0] F_SRL  = 4'b1001;
   localparam logic [3:0] F_SRA  = 4'b1010;
   localparam logic [3:0] F_MUL  = 4'b1011;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   typedef struct packed {
      logic             err;
      logic [3:0]       flags;
      logic [WIDTH-1:0] y;
   } ent_t;

   state_t           state;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   ent_t             mem [2];
   logic             wp;
   logic             rp;
   logic [1:0]       fifo_count;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_y;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;
   logic [WIDTH-1:0] mul_res;
   logic             accept;
   logic             push;
   logic             pop;
   ent_t             push_ent;

   assign req_ready = (state == ST_IDLE) && (fifo_count < 2'd2);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (fifo_count != 2'd0);
   assign pop       = rsp_valid && rsp_ready;

   assign rsp_y     = mem[rp].y;
   assign rsp_flags = mem[rp].flags;
   assign rsp_err   = mem[rp].err;

   assign sum  = {1'b0, req_a} + {1'b0, req_b};
   assign diff = {1'b0, req_a} + {1'b0, ~req_b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (req_f)
         F_AND:  alu_y = req_a & req_b;
         F_OR:   alu_y = req_a | req_b;
         F_ADD: begin
            alu_y = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (sum[WIDTH-1] != req_a[WIDTH-1]);
         end
         F_XOR:  alu_y = req_a ^ req_b;
         F_ANDN: alu_y = req_a & ~req_b;
         F_ORN:  alu_y = req_a | ~req_b;
         F_SUB: begin
            alu_y = diff[WIDTH-1:0];
            alu_c = diff[WIDTH];
            alu_v = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (diff[WIDTH-1] != req_a[WIDTH-1]);
         end
         F_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
         F_SLL:  alu_y = req_a << req_b[4:0];
         F_SRL:  alu_y = req_a >> req_b[4:0];
         F_SRA:  alu_y = $signed(req_a) >>> req_b[4:0];
         F_MUL:  alu_y = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // Final step folds the last multiplier bit in combinationally so the
   // result can be pushed on the same edge that finishes the sequence.
   assign mul_res = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      push     = 1'b0;
      push_ent = '0;
      if (state == ST_MUL) begin
         if (cnt == 5'd31) begin
            push     = 1'b1;
            push_ent = '{err: 1'b0,
                         flags: {mul_res[WIDTH-1], (mul_res == '0), 2'b00},
                         y: mul_res};
         end
      end else if (accept && (req_f != F_MUL)) begin
         push     = 1'b1;
         push_ent = '{err: alu_err,
                      flags: {alu_y[WIDTH-1], (alu_y == '0), alu_c, alu_v},
                      y: alu_y};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && (req_f == F_MUL)) begin
                  mcand  <= req_a;
                  mplier <= req_b;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= ST_MUL;
               end
            end
            ST_MUL: begin
               acc    <= mul_res;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               if (cnt == 5'd31) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         wp         <= 1'b0;
         rp         <= 1'b0;
         fifo_count <= '0;
         op_count   <= '0;
      end else begin
         if (push) begin
            mem[wp] <= push_ent;
            wp      <= ~wp;
         end
         if (pop) begin
            rp       <= ~rp;
            op_count <= op_count + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // MUL is only accepted with a free slot and nothing else pushes meanwhile.
   a_mul_push_room: assert property (@(posedge clk) disable iff (rst)
      ((state == ST_MUL) && (cnt == 5'd31)) |-> (fifo_count < 2'd2));

endmodule
